// File: rtl/switch_scheduler.sv
// switch_scheduler: 4x4 output scheduler with one holding slot per input.
// Each output grants one waiting slot per cycle, using its own round-robin pointer.
// A granted slot can take a new packet at the same edge it is granted.
// Optional build macro SWITCH_SCHEDULER_CONFLICT_CNT_EN adds a saturating counter
// of cycles in which some full slot lost arbitration.
// Without the macro, conflict_count is tied to zero.
module switch_scheduler #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0]      in_valid,
    input  logic [7:0]      in_dest,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic [3:0]      out_valid,
    output logic [4*DW-1:0] out_data,
    output logic [7:0]      out_src,
    output logic [CW-1:0]   conflict_count
);

    logic [3:0]          full;
    logic [3:0][1:0]     slot_dest;
    logic [3:0][DW-1:0]  slot_data;
    logic [3:0][1:0]     ptr;

    logic [3:0]          grant;
    logic [3:0]          out_hit;
    logic [3:0][1:0]     win;
    logic [1:0]          k;

    // For each output, pick the first waiting slot at or after its pointer.
    // A slot targets only one output, so it can be granted at most once.
    always_comb begin
        grant   = '0;
        out_hit = '0;
        win     = '0;
        k       = '0;
        for (int o = 0; o < 4; o++) begin
            for (int j = 0; j < 4; j++) begin
                k = ptr[o] + j[1:0];
                if (!out_hit[o] && full[k] && (slot_dest[k] == o[1:0])) begin
                    out_hit[o] = 1'b1;
                    win[o]     = k;
                    grant[k]   = 1'b1;
                end
            end
        end
    end

    // An empty slot is ready, and so is a slot that is being granted this cycle.
    assign in_ready = ~full | grant;

    // Move granted packets into the output registers and refill or free the slots.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full      <= '0;
            slot_dest <= '0;
            slot_data <= '0;
            ptr       <= '0;
            out_valid <= '0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (out_hit[o]) begin
                    out_valid[o]            <= 1'b1;
                    out_data[o*DW +: DW]    <= slot_data[win[o]];
                    out_src[2*o +: 2]       <= win[o];
                    ptr[o]                  <= win[o] + 2'd1;
                end else begin
                    out_valid[o] <= 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    full[i]      <= 1'b1;
                    slot_dest[i] <= in_dest[2*i +: 2];
                    slot_data[i] <= in_data[i*DW +: DW];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SWITCH_SCHEDULER_CONFLICT_CNT_EN
    logic conflict;
    logic [CW-1:0] conflict_q;

    assign conflict = |(full & ~grant);

    // Count cycles in which a full slot lost arbitration, stopping at the maximum value.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            conflict_q <= '0;
        end else if (conflict && (conflict_q != {CW{1'b1}})) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = '0;
`endif

endmodule
